// File: rtl/divider_pkg.sv
// divider_pkg: state encoding, result width and magnitude helper for the divider
package divider_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DIVZERO = 2'd1, ON = 2'd2, END = 2'd3} state_t;
  localparam int RES_W = 64;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? -x : x;
  endfunction
endpackage

// File: rtl/divider.sv
// divider: iterative 32-bit signed/unsigned restoring divider, result = {remainder, quotient}
module divider import divider_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             signed_div,
  input  logic             start,
  input  logic             annul,
  output logic [RES_W-1:0] result,
  output logic             ready,
  output logic             busy
);
  state_t state;
  logic [5:0] cnt;
  logic [31:0] rem, quo, dvs, a_l, nrem, nquo;
  logic neg_q, neg_r;
  logic [32:0] trial, sub;
  // sub[32] set means the trial remainder was smaller than the divisor
  always_comb begin
    trial = {rem, quo[31]};
    sub = trial - {1'b0, dvs};
    nrem = sub[32] ? trial[31:0] : sub[31:0];
    nquo = {quo[30:0], ~sub[32]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      result <= '0;
      ready <= 1'b0;
      busy <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      a_l <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (start && !annul) begin
          a_l <= a;
          dvs <= mag(b, signed_div);
          quo <= mag(a, signed_div);
          rem <= '0;
          cnt <= '0;
          neg_q <= signed_div & (a[31] ^ b[31]);
          neg_r <= signed_div & a[31];
          state <= (b == '0) ? DIVZERO : ON;
          busy <= 1'b1;
        end
        DIVZERO: if (annul) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          result <= {a_l, 32'hFFFF_FFFF};
          ready <= 1'b1;
          state <= END;
        end
        ON: if (annul) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          rem <= nrem;
          quo <= nquo;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            result <= {neg_r ? -nrem : nrem, neg_q ? -nquo : nquo};
            ready <= 1'b1;
            state <= END;
          end
        end
        END: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed and random checks of divider against an arithmetic reference
module tb_divider;
  logic clk = 0, rst = 1, signed_div = 0, start = 0, annul = 0;
  logic [31:0] a = 0, b = 0;
  logic [63:0] result, prev;
  logic ready, busy, bz;
  int pass = 0, total = 0, n;

  always #5 clk = ~clk;

  divider dut (.clk(clk), .rst(rst), .a(a), .b(b), .signed_div(signed_div),
               .start(start), .annul(annul), .result(result), .ready(ready), .busy(busy));

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    if (y == 0) return {x, 32'hFFFF_FFFF};
    if (!s) return {x % y, x / y};
    sx = $signed(x);
    sy = $signed(y);
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s);
    a = x; b = y; signed_div = s; start = 1;
    @(posedge clk); #1;
    start = 0; a = $urandom; b = $urandom; signed_div = $urandom_range(0, 1);
  endtask

  task automatic wait_ready(output int cnt, output logic bsy);
    cnt = 0; bsy = 1;
    while (!ready && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      bsy &= busy;
    end
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic s);
    launch(x, y, s);
    wait_ready(n, bz);
    chk("latency", 64'(n), (y == 0) ? 64'd1 : 64'd32);
    chk("result", result, model(x, y, s));
    chk("busy_during_op", {63'd0, bz}, 64'd1);
    @(posedge clk); #1;
    chk("ready_pulse_busy_idle", {62'd0, ready, busy}, 64'd0);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {result[61:0], ready, busy}, 64'd0);
    @(posedge clk); #1 rst = 0;
    // directed cases
    op(100, 7, 0);
    chk("100/7", result, {32'd2, 32'd14});
    op(32'hFFFF_FFF9, 2, 1);
    chk("-7/2 signed", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    op(32'hFFFF_FFF9, 2, 0);
    chk("-7/2 unsigned", result, {32'd1, 32'h7FFF_FFFC});
    op(5, 0, 0);
    chk("5/0", result, {32'd5, 32'hFFFF_FFFF});
    op(32'h8000_0000, 32'hFFFF_FFFF, 1);
    chk("minint/-1", result, {32'd0, 32'h8000_0000});
    // start with annul in IDLE is ignored
    a = 50; b = 5; start = 1; annul = 1;
    @(posedge clk); #1 start = 0; annul = 0;
    chk("start_annul_ignored", {63'd0, busy}, 64'd0);
    // annul mid-division
    prev = result;
    launch(1000, 3, 0);
    repeat (10) @(posedge clk);
    #1 annul = 1;
    @(posedge clk); #1 annul = 0;
    chk("annul_busy_drop", {62'd0, busy, ready}, 64'd0);
    bz = 0;
    repeat (40) begin @(posedge clk); #1 bz |= ready; end
    chk("annul_no_ready", {63'd0, bz}, 64'd0);
    chk("annul_result_held", result, prev);
    op(9, 3, 0);
    chk("9/3", result, {32'd0, 32'd3});
    // second start during ON is ignored
    launch(1234567, 89, 0);
    repeat (4) @(posedge clk);
    #1 a = 77; b = 0; start = 1;
    @(posedge clk); #1 start = 0;
    wait_ready(n, bz);
    chk("restart_latency", 64'(n), 64'd27);
    chk("restart_ignored", result, model(1234567, 89, 0));
    @(posedge clk); #1;
    // async reset mid-division
    launch(32'hDEAD_BEEF, 17, 0);
    repeat (19) @(posedge clk);
    #2 rst = 1;
    #1 chk("async_reset", {result[61:0], ready, busy}, 64'd0);
    @(posedge clk); #1 rst = 0;
    op(20, 6, 0);
    chk("20/6", result, {32'd2, 32'd3});
    // random back-to-back operations
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = (i % 6 == 0) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 4 == 1) y = -y;
      op(x, y, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
